dcache_controller: RTL

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller_pkg.sv | 26 ++
 rtl/dcache_controller_if.sv | 28 ++
 rtl/dcache_sram.sv | 44 ++++
 rtl/dcache_controller.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-back data cache.
package dcache_controller_pkg;

    localparam int LINES      = 32;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WORDS      = LINE_W / WORD_W;
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 5;
    localparam int WORD_SEL_W = 3;
    localparam int OFFSET_W   = 5;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_MISS       = 3'd1;
    localparam logic [2:0] ST_WRITEBACK  = 3'd2;
    localparam logic [2:0] ST_READMISS   = 3'd3;
    localparam logic [2:0] ST_READMISSOK = 3'd4;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signals of the data cache; master is the controller.
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_addr_i;
    logic [WORD_W-1:0] p1_data_i;
    logic [WORD_W-1:0] p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [31:0]       mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    modport master (
        input  p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output p1_MemRead_i, p1_MemWrite_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Line store: combinational read, synchronous write; only valid/dirty are cleared by reset.
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_entry,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_entry
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid_reg;
    logic [LINES-1:0]  dirty_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (we) begin
            valid_reg[wr_idx] <= wr_entry.valid;
            dirty_reg[wr_idx] <= wr_entry.dirty;
        end
    end

    // Tag/data carry no reset: a cleared valid bit hides whatever they hold.
    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_entry.tag;
            data_mem[wr_idx] <= wr_entry.data;
        end
    end

    always_comb begin
        rd_entry.valid = valid_reg[rd_idx];
        rd_entry.dirty = dirty_reg[rd_idx];
        rd_entry.tag   = tag_mem[rd_idx];
        rd_entry.data  = data_mem[rd_idx];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// five-state miss FSM (write back dirty victim, then refill).
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.master bus
);

    logic [2:0]          state_reg, state_next;
    logic                mem_enable_reg, mem_enable_next;
    logic                mem_write_reg, mem_write_next;
    logic [31:0]         mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0]   mem_data_reg, mem_data_next;

    logic [TAG_W-1:0]      cpu_tag;
    logic [IDX_W-1:0]      cpu_idx;
    logic [WORD_SEL_W-1:0] cpu_wsel;
    logic [31:0]           refill_addr;
    logic                  req, hit, sram_we;
    line_t                 rd_entry, wr_entry;
    logic [LINE_W-1:0]     merged_line;
    logic [WORD_W-1:0]     line_words [WORDS];
    logic                  unused_byte_sel;

    assign cpu_tag         = bus.p1_addr_i[31:10];
    assign cpu_idx         = bus.p1_addr_i[9:5];
    assign cpu_wsel        = bus.p1_addr_i[4:2];
    assign unused_byte_sel = ^bus.p1_addr_i[1:0];
    assign refill_addr     = {bus.p1_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (cpu_idx),
        .rd_entry (rd_entry),
        .we       (sram_we),
        .wr_idx   (cpu_idx),
        .wr_entry (wr_entry)
    );

    // Split the stored line into words and build the store-merged line.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = rd_entry.data[gi*WORD_W +: WORD_W];
            assign merged_line[gi*WORD_W +: WORD_W] =
                (cpu_wsel == WORD_SEL_W'(gi)) ? bus.p1_data_i : rd_entry.data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign req = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    assign hit = rd_entry.valid & (rd_entry.tag == cpu_tag);

    assign bus.p1_stall_o   = (state_reg == ST_IDLE) ? (req & ~hit) : 1'b1;
    assign bus.p1_data_o    = (bus.p1_MemRead_i && hit) ? line_words[cpu_wsel] : '0;
    assign bus.mem_enable_o = mem_enable_reg;
    assign bus.mem_write_o  = mem_write_reg;
    assign bus.mem_addr_o   = mem_addr_reg;
    assign bus.mem_data_o   = mem_data_reg;

    always_comb begin
        state_next      = state_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        sram_we         = 1'b0;
        wr_entry        = rd_entry;
        case (state_reg)
            ST_IDLE: begin
                if (req && !hit) begin
                    state_next = ST_MISS;
                end else if (bus.p1_MemWrite_i && hit) begin
                    sram_we        = 1'b1;
                    wr_entry.dirty = 1'b1;
                    wr_entry.data  = merged_line;
                end
            end
            ST_MISS: begin
                mem_enable_next = 1'b1;
                if (rd_entry.valid && rd_entry.dirty) begin
                    mem_write_next = 1'b1;
                    mem_addr_next  = {rd_entry.tag, cpu_idx, {OFFSET_W{1'b0}}};
                    mem_data_next  = rd_entry.data;
                    state_next     = ST_WRITEBACK;
                end else begin
                    mem_write_next = 1'b0;
                    mem_addr_next  = refill_addr;
                    state_next     = ST_READMISS;
                end
            end
            ST_WRITEBACK: begin
                // Request stays up across the ack; only direction and address flip.
                if (bus.mem_ack_i) begin
                    mem_write_next = 1'b0;
                    mem_addr_next  = refill_addr;
                    state_next     = ST_READMISS;
                end
            end
            ST_READMISS: begin
                if (bus.mem_ack_i) begin
                    sram_we         = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.dirty  = 1'b0;
                    wr_entry.tag    = cpu_tag;
                    wr_entry.data   = bus.mem_data_i;
                    mem_enable_next = 1'b0;
                    state_next      = ST_READMISSOK;
                end
            end
            ST_READMISSOK: state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= ST_IDLE;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
        end
    end

endmodule
